// File: rtl/merge_fifo_if.sv
// Handshake bundle between a merge_fifo and its writer/reader.
// count exists only when MERGE_FIFO_COUNT_EN is defined.
interface merge_fifo_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [DATA_W-1:0] din;
    logic              enq;
    logic              full;
    logic [DATA_W-1:0] dout;
    logic              valid;
    logic              deq;
    logic              flush;
`ifdef MERGE_FIFO_COUNT_EN
    logic [ADDR_W:0]   count;
`endif

    modport master (
        output din, enq, deq, flush,
`ifdef MERGE_FIFO_COUNT_EN
        input  count,
`endif
        input  full, dout, valid
    );

    modport slave (
        input  din, enq, deq, flush,
`ifdef MERGE_FIFO_COUNT_EN
        output count,
`endif
        output full, dout, valid
    );
endinterface

// File: rtl/merge_fifo.sv
// First-word-fall-through queue on each merge tree edge.
// Optional occupancy port: define MERGE_FIFO_COUNT_EN.
module merge_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    merge_fifo_if.slave  bus
);
    localparam int DEPTH_N = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W-1:0] mem [DEPTH_N];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   occ;
    logic [ADDR_W:0]   occ_nxt;
    logic              wr_ok;
    logic              rd_ok;
    logic              full;
    logic              valid;

    // Status is derived from registered state only, keeping the
    // comparator interlock free of combinational loops.
    assign full  = (occ == DEPTH);
    assign valid = (occ != '0);
    assign wr_ok = bus.enq & ~full;
    assign rd_ok = bus.deq & valid;

    assign bus.full  = full;
    assign bus.valid = valid;
    assign bus.dout  = valid ? mem[rd_ptr] : '0;
`ifdef MERGE_FIFO_COUNT_EN
    assign bus.count = occ;
`endif

    always_comb begin
        occ_nxt = occ;
        unique case (1'b1)
            (wr_ok && !rd_ok): occ_nxt = occ + (ADDR_W+1)'(1);
            (rd_ok && !wr_ok): occ_nxt = occ - (ADDR_W+1)'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
            occ <= occ_nxt;
        end
    end

    // Storage is never cleared; stale words are masked by valid.
    always_ff @(posedge clk) begin
        if (wr_ok && !bus.flush) mem[wr_ptr] <= bus.din;
    end
endmodule

// File: tb/tb_merge_fifo.sv
// Directed bench for merge_fifo with a queue scoreboard.
// Also merges two preloaded queues into a third.
module tb_merge_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_c[$];

    merge_fifo_if #(.DATA_W(32), .ADDR_W(2)) f ();
    merge_fifo #(.DATA_W(32), .ADDR_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(f));

    merge_fifo_if #(.DATA_W(32), .ADDR_W(3)) m_a ();
    merge_fifo_if #(.DATA_W(32), .ADDR_W(3)) m_b ();
    merge_fifo_if #(.DATA_W(32), .ADDR_W(3)) m_c ();
    merge_fifo #(.DATA_W(32), .ADDR_W(3)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(m_a));
    merge_fifo #(.DATA_W(32), .ADDR_W(3)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(m_b));
    merge_fifo #(.DATA_W(32), .ADDR_W(3)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(m_c));

    logic merge_en = 1'b0;
    logic ld_en = 1'b0;
    logic [31:0] ld_a = '0;
    logic [31:0] ld_b = '0;
    logic c_deq = 1'b0;
    logic pick_a, pick_b;

    // Comparator: pops the smaller head into m_c.
    always_comb begin
        pick_a = merge_en && m_a.valid && m_b.valid && !m_c.full
                 && (m_a.dout <= m_b.dout);
        pick_b = merge_en && m_a.valid && m_b.valid && !m_c.full
                 && (m_b.dout < m_a.dout);
        m_a.enq = ld_en;
        m_a.din = ld_a;
        m_a.deq = pick_a;
        m_a.flush = 1'b0;
        m_b.enq = ld_en;
        m_b.din = ld_b;
        m_b.deq = pick_b;
        m_b.flush = 1'b0;
        m_c.enq = pick_a | pick_b;
        m_c.din = pick_a ? m_a.dout : m_b.dout;
        m_c.deq = c_deq;
        m_c.flush = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".valid"}, 32'(f.valid), 32'(sb.size() != 0));
        chk({tag, ".full"}, 32'(f.full), 32'(sb.size() == 4));
        chk({tag, ".dout"}, f.dout, (sb.size() != 0) ? sb[0] : 32'h0);
`ifdef MERGE_FIFO_COUNT_EN
        chk({tag, ".count"}, 32'(f.count), 32'(sb.size()));
`endif
    endtask

    // Drive one cycle, check outputs before the edge, update model.
    task automatic cycle(input logic e, input logic [31:0] d,
                         input logic q, input logic fl, input string tag);
        logic wr, rd;
        f.enq = e;
        f.din = d;
        f.deq = q;
        f.flush = fl;
        check_state(tag);
        wr = e && (sb.size() < 4);
        rd = q && (sb.size() > 0);
        if (fl) sb.delete();
        else begin
            if (rd) void'(sb.pop_front());
            if (wr) sb.push_back(d);
        end
        @(posedge clk);
        #1;
        f.enq = 1'b0;
        f.deq = 1'b0;
        f.flush = 1'b0;
    endtask

    initial begin
        f.enq = 1'b0;
        f.deq = 1'b0;
        f.flush = 1'b0;
        f.din = '0;
        #12;
        check_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("idle");

        // Fill and overfill
        cycle(1, 32'h11, 0, 0, "fill0");
        cycle(1, 32'h22, 0, 0, "fill1");
        cycle(1, 32'h33, 0, 0, "fill2");
        cycle(1, 32'h44, 0, 0, "fill3");
        chk("full_after4", 32'(f.full), 32'd1);
        cycle(1, 32'h55, 0, 0, "overfill");
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, "drain");
        chk("drained_valid", 32'(f.valid), 32'd0);

        // Wrap-around
        for (int i = 0; i < 3; i++) cycle(1, 32'(i + 1), 0, 0, "wp");
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, "wq");
        for (int i = 0; i < 4; i++) cycle(1, 32'hA0 + 32'(i), 0, 0, "wpush");
        chk("wrap_head", f.dout, 32'hA0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, "wdrain");

        // Simultaneous enq+deq at occ=2
        cycle(1, 32'h100, 0, 0, "s0");
        cycle(1, 32'h101, 0, 0, "s1");
        for (int i = 0; i < 10; i++)
            cycle(1, 32'h102 + 32'(i), 1, 0, "steady");
        chk("steady_valid", 32'(f.valid), 32'd1);
        chk("steady_full", 32'(f.full), 32'd0);
        cycle(0, 0, 1, 0, "sd0");
        cycle(0, 0, 1, 0, "sd1");

        // Empty: enq+deq keeps the write
        cycle(1, 32'h7, 1, 0, "empty_both");
        chk("empty_both_dout", f.dout, 32'h7);
        cycle(0, 0, 1, 0, "e_pop");

        // Full: enq+deq refuses the write
        for (int i = 0; i < 4; i++) cycle(1, 32'h20 + 32'(i), 0, 0, "ff");
        cycle(1, 32'h9, 1, 0, "full_both");
        chk("full_both_full", 32'(f.full), 32'd0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, "fdrain");
        chk("no_9", 32'(f.valid), 32'd0);

        // Flush beats enq
        for (int i = 0; i < 3; i++) cycle(1, 32'h30 + 32'(i), 0, 0, "pf");
        cycle(1, 32'h5, 0, 1, "flush");
        chk("flush_valid", 32'(f.valid), 32'd0);
        cycle(1, 32'h6, 0, 0, "post_flush");
        chk("post_flush_dout", f.dout, 32'h6);
        cycle(0, 0, 1, 0, "pf_pop");

        // Async reset mid-cycle
        cycle(1, 32'h40, 0, 0, "r0");
        cycle(1, 32'h41, 0, 0, "r1");
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("arst_valid", 32'(f.valid), 32'd0);
        check_state("arst");
        #1;
        rst_n = 1'b1;
        cycle(1, 32'h66, 0, 0, "first_wr");
        chk("first_wr_dout", f.dout, 32'h66);
        cycle(0, 0, 1, 0, "fw_pop");
        check_state("end_main");

        // Merge integration
        for (int i = 0; i < 3; i++) begin
            ld_en = 1'b1;
            ld_a = (i == 0) ? 32'd1 : (i == 1) ? 32'd4 : 32'd9;
            ld_b = (i == 0) ? 32'd2 : (i == 1) ? 32'd3 : 32'd10;
            @(posedge clk);
            #1;
        end
        ld_en = 1'b0;
        exp_c = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd9};
        merge_en = 1'b1;
        for (int i = 0; i < 20 && m_a.valid && m_b.valid; i++) begin
            @(posedge clk);
            #1;
        end
        merge_en = 1'b0;
        chk("merge_done_a", 32'(m_a.valid), 32'd0);
        chk("merge_left_b", m_b.dout, 32'd10);
        while (exp_c.size() != 0) begin
            c_deq = 1'b1;
            chk("merge_out", m_c.dout, exp_c.pop_front());
            @(posedge clk);
            #1;
        end
        c_deq = 1'b0;
        chk("merge_c_empty", 32'(m_c.valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/merge_fifo.md
# merge_fifo

Synchronous first-word-fall-through queue that terminates the merge comparator's `enq`/`full` output protocol and sources its `valid`/`deq` input protocol. One instance sits on every edge of the merge tree: the leaf loaders write into it, each comparator drains two instances and fills one. The combinational comparator interlock holds only if this block meets the handshake rules below.

## Interface
- `DATA_W`, 32: payload width.
- `ADDR_W`, 4: pointer width. Depth is `DEPTH = 2**ADDR_W` entries, so depth is always a power of two.

- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `din`  in  DATA_W: write data.
- `enq`  in  1: write request, sampled at the rising edge.
- `full`  out  1: queue holds DEPTH entries.
- `dout`  out  DATA_W: head entry, valid combinationally while `valid` = 1.
- `valid`  out  1: queue is non-empty.
- `deq`  in  1: pop the head entry at the rising edge.
- `flush`  in  1: synchronous clear, used between sort passes.
- `count`  out  ADDR_W+1: occupancy. Present only with `MERGE_FIFO_COUNT_EN`.

## Operation
- Storage: DEPTH x DATA_W register array, a write pointer `wr_ptr[ADDR_W-1:0]` and a read pointer `rd_ptr[ADDR_W-1:0]`.
- Occupancy register `occ[ADDR_W:0]` ranges 0..DEPTH.
- Pointers wrap modulo DEPTH by natural overflow; no explicit compare is needed.
- Outputs:
  - `full` = (`occ` == DEPTH).
  - `valid` = (`occ` != 0).
  - `dout` = `mem[rd_ptr]` when `valid`, otherwise all zeros.
- Write accepted: `wr_ok` = `enq` & ~`full`. It stores `din` at `wr_ptr` and increments `wr_ptr`.
- Read accepted: `rd_ok` = `deq` & `valid`. It increments `rd_ptr`.
- Occupancy update:
  - `occ` += 1 if only `wr_ok`.
  - `occ` -= 1 if only `rd_ok`.
  - `occ` unchanged if both or neither.
- Ignored requests leave all state unchanged and raise no error:
  - `enq` while full: write dropped (the writer must not do this).
  - `deq` while empty.
- Full plus simultaneous `deq` and `enq`: the write is still refused, because `full` is evaluated on current state. The comparator already gates `enq` with `!full`, so nothing is lost.
- Empty plus simultaneous `enq` and `deq`: the `deq` is ignored and the write is accepted. The entry becomes visible in the next cycle. There is no bypass path.
- Simultaneous `enq` and `deq` with 0 < `occ` < DEPTH: both take effect and `occ` is unchanged.
- `flush` has priority over `enq` and `deq`. It clears `wr_ptr`, `rd_ptr` and `occ` at the next edge. Array contents are not cleared.

## Timing
- Reset values (asynchronous, while `rst_n` = 0): `wr_ptr` = `rd_ptr` = 0, `occ` = 0. Therefore `valid` = 0, `full` = 0, `dout` = 0 and `count` = 0.
- The array is not reset.
- Write-to-read latency is 1 cycle. After an `enq` accepted at edge N, `valid` and `dout` reflect the entry from edge N onward, i.e. it is usable in the following cycle.
- Pop: after an accepted `deq` at edge N, the next entry (or `valid` = 0) appears after edge N.
- `full`, `valid` and `dout` depend only on registered state, never on `enq`, `deq` or `din`. This breaks any combinational loop through the comparator.
- Reset asserted mid-stream discards all contents immediately. The first write after `rst_n` rises is accepted on the first rising edge.
- Sustained throughput is one write and one read per cycle at any non-boundary occupancy.

## Configuration
- `MERGE_FIFO_COUNT_EN` defined: the `count` output port exists and equals `occ`, with the same timing as `full`/`valid`. It is used by pass control to detect run ends.
- `MERGE_FIFO_COUNT_EN` undefined: the port is absent. `occ` is still kept internally; behaviour is otherwise identical.

## Test plan
- Reset then idle, ADDR_W = 2:
  - `valid` = 0, `full` = 0, `dout` = 0.
  - `count` = 0 (if `MERGE_FIFO_COUNT_EN`).
- Fill and overfill:
  - `enq` 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then `enq` 0x55 → `full` = 1 after the 4th write, 0x55 dropped.
  - Drain yields 0x11, 0x22, 0x33, 0x44 in order, then `valid` = 0.
- Wrap-around: push 3, pop 3, push 0xA0..0xA3 → dout order 0xA0, 0xA1, 0xA2, 0xA3 with `wr_ptr` wrapped.
- Simultaneous events:
  - At `occ` = 2, `enq`+`deq` for 10 cycles → `occ` stays 2 and output order is preserved.
  - At empty, `enq` 0x7 plus `deq` → 0x7 still present next cycle.
  - At full, `enq` 0x9 plus `deq` → `occ` = 3 and 0x9 is absent.
- Flush and reset mid-stream:
  - With 3 entries, `flush` together with `enq` 0x5 → `occ` = 0, `valid` = 0, and 0x5 is not stored.
  - Async `rst_n` low mid-cycle at `occ` = 2 → `valid` = 0 before the next edge.
- Merge integration: two instances preloaded with 1,4,9 and 2,3,10 feed the comparator, which writes into a third instance → third instance holds 1,2,3,4,9 (the final 10 waits, since `valid_1` = 0).
